// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and constants for the PE SRAM controller
package pe_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam int PE_SRAM_RSP_DEPTH = 2;
  localparam int PE_DATA_W         = 32;

  typedef struct packed {
    logic [PE_DATA_W-1:0] rdata;
    logic                 err;
  } rsp_entry_t;

endpackage

// File: rtl/pe_sram_ctrl_if.sv
// rtl/pe_sram_ctrl_if.sv - request/response channel between a requester and pe_sram_ctrl
interface pe_sram_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADR_W  = 12
);
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [ADR_W+1:0]    req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_wstrb;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/pe_rsp_fifo.sv
// rtl/pe_rsp_fifo.sv - 2-entry in-order synchronous FIFO with occupancy count
module pe_rsp_fifo
  import pe_pkg::*;
#(
  parameter int W = $bits(rsp_entry_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [PE_SRAM_RSP_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         do_push;
  logic         do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q < 2'(PE_SRAM_RSP_DEPTH)) || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < PE_SRAM_RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/pe_sram_ctrl.sv
// rtl/pe_sram_ctrl.sv - request/response front end that owns the pe_sram single port
// Optional zero-fill of the array after reset: define PE_SRAM_CTRL_INIT_EN.
module pe_sram_ctrl
  import pe_pkg::*;
#(
  parameter int SIZE   = 4096,
  parameter int DATA_W = 32,
  parameter int ADR_W  = 12
) (
  input  logic                clk,
  input  logic                rst,
  pe_sram_ctrl_if.slave       bus,
  output logic                init_done,
  output logic                sram_en,
  output logic                sram_we,
  output logic [ADR_W-1:0]    sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W/8-1:0] sram_wstrb,
  input  logic [DATA_W-1:0]   sram_rdata
);
  localparam logic [ADR_W:0] WORDS = (ADR_W+1)'(SIZE / 4);

  state_e           state_q;
  logic             run;
  logic [ADR_W-1:0] word;
  logic             addr_err;
  logic             accept;
  logic             pop;
  logic [1:0]       fifo_count;
  logic             head_valid;
  rsp_entry_t       push_entry;
  rsp_entry_t       head_entry;

  // Gating with rst keeps every output at its idle value while reset is held.
  assign run       = (state_q == ST_RUN) && !rst;
  assign init_done = run;

  assign word     = bus.req_addr[ADR_W+1:2];
  assign addr_err = (bus.req_addr[1:0] != 2'b00) || ({1'b0, word} >= WORDS);

  assign bus.req_ready = run && (fifo_count < 2'(PE_SRAM_RSP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = head_valid && bus.rsp_ready;

`ifdef PE_SRAM_CTRL_INIT_EN
  logic [ADR_W-1:0] init_cnt_q;
  logic             init_last;

  assign init_last = ({1'b0, init_cnt_q} == (WORDS - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      init_cnt_q <= init_last ? '0 : init_cnt_q + ADR_W'(1);
      if (init_last) begin
        state_q <= ST_RUN;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end
  end
`endif

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wstrb = '0;
`ifdef PE_SRAM_CTRL_INIT_EN
    if ((state_q == ST_INIT) && !rst) begin
      sram_en    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = init_cnt_q;
      sram_wstrb = '1;
    end
`endif
    // Rejected requests never touch the array.
    if (accept && !addr_err) begin
      sram_en    = 1'b1;
      sram_we    = bus.req_we;
      sram_addr  = word;
      sram_wdata = bus.req_wdata;
      sram_wstrb = bus.req_wstrb;
    end
  end

  always_comb begin
    push_entry.err   = addr_err;
    push_entry.rdata = (!bus.req_we && !addr_err) ? sram_rdata : '0;
  end

  pe_rsp_fifo #(
    .W($bits(rsp_entry_t))
  ) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (accept),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .head_o     (head_entry),
    .valid_o    (head_valid),
    .count_o    (fifo_count)
  );

  assign bus.rsp_valid = head_valid;
  assign bus.rsp_rdata = head_entry.rdata;
  assign bus.rsp_err   = head_entry.err;

endmodule

// File: tb/tb_pe_sram_ctrl.sv
// tb/tb_pe_sram_ctrl.sv - self-checking bench for pe_sram_ctrl (SIZE=64, either PE_SRAM_CTRL_INIT_EN setting)
module tb_pe_sram_ctrl;
  localparam int SIZE  = 64;
  localparam int ADR_W = 5;
  localparam int NW    = 1 << ADR_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             init_done;
  logic             sram_en;
  logic             sram_we;
  logic [ADR_W-1:0] sram_addr;
  logic [31:0]      sram_wdata;
  logic [3:0]       sram_wstrb;
  logic [31:0]      sram_rdata;

  pe_sram_ctrl_if #(.DATA_W(32), .ADR_W(ADR_W)) bus ();

  pe_sram_ctrl #(.SIZE(SIZE), .DATA_W(32), .ADR_W(ADR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .init_done (init_done),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_wstrb(sram_wstrb),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Stand-in for pe_sram: combinational read, byte-enabled write on the clock edge.
  logic [31:0] sram_arr [NW];
  logic [31:0] seed [NW];
  logic        load_seed;
  assign sram_rdata = sram_arr[sram_addr];
  always @(posedge clk) begin
    if (load_seed) begin
      for (int i = 0; i < NW; i++) sram_arr[i] <= seed[i];
    end else if (sram_en && sram_we) begin
      for (int b = 0; b < 4; b++)
        if (sram_wstrb[b]) sram_arr[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  // Reference model: byte-addressed memory plus the queue of expected responses.
  logic [7:0]  ref_mem [SIZE];
  logic [32:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input int a);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem[a + b];
    return w;
  endfunction

  task automatic issue(input logic we, input logic [ADR_W+1:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    logic        err;
    logic [31:0] rd;
    int          k;
    err = (addr[1:0] != 2'b00) || (int'(addr) >= SIZE);
    rd  = '0;
    if (!err && !we) rd = rd_word(int'(addr));
    if (!err && we)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ref_mem[int'(addr) + b] = wdata[8*b +: 8];
    exp_q.push_back({err, rd});
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    #1;
    k = 0;
    while (bus.req_ready !== 1'b1 && k < 50) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("req_accept_in_time", (k < 50), 1'b1);
    chk("sram_en_on_accept", sram_en, !err);
    if (!err) begin
      chk("sram_we_on_accept", sram_we, we);
      chk("sram_addr_on_accept", sram_addr, addr[ADR_W+1:2]);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic check_rsp(input string tag);
    logic [32:0] e;
    #1;
    e = exp_q.pop_front();
    chk({tag, "_valid"}, bus.rsp_valid, 1'b1);
    chk({tag, "_rdata"}, bus.rsp_rdata, e[31:0]);
    chk({tag, "_err"}, bus.rsp_err, e[32]);
    chk({tag, "_idle_en"}, sram_en, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic walk(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("init_en", sram_en, 1'b1);
      chk("init_we", sram_we, 1'b1);
      chk("init_addr", sram_addr, i);
      chk("init_wdata", sram_wdata, 32'h0);
      chk("init_wstrb", sram_wstrb, 4'hF);
      chk("init_req_ready", bus.req_ready, 1'b0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_run();
    rst = 1'b0;
`ifdef PE_SRAM_CTRL_INIT_EN
    walk(SIZE / 4);
    for (int b = 0; b < SIZE; b++) ref_mem[b] = 8'h00;
`endif
    #1;
    chk("run_req_ready", bus.req_ready, 1'b1);
    chk("run_init_done", init_done, 1'b1);
    chk("run_idle_en", sram_en, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [ADR_W+1:0] a;
    logic [31:0]      ea, eb, ec;
    int               mode;

    for (int i = 0; i < NW; i++) seed[i] = $urandom;
    for (int b = 0; b < SIZE; b++) ref_mem[b] = seed[b / 4][8*(b % 4) +: 8];
    load_seed     = 1'b1;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    load_seed = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_sram_en", sram_en, 1'b0);
    chk("rst_sram_we", sram_we, 1'b0);
    chk("rst_sram_addr", sram_addr, '0);
    chk("rst_sram_wdata", sram_wdata, 32'h0);
    chk("rst_sram_wstrb", sram_wstrb, 4'h0);
    @(posedge clk);
    #1;

`ifdef PE_SRAM_CTRL_INIT_EN
    rst = 1'b0;
    walk(5);
    rst = 1'b1;
    #1;
    chk("midinit_rst_en", sram_en, 1'b0);
    @(posedge clk);
    #1;
`endif
    release_run();

    issue(1'b1, 7'h10, 32'hDEADBEEF, 4'hF);
    check_rsp("wr_ack");
    issue(1'b0, 7'h10, 32'h0, 4'h0);
    check_rsp("rd_back");
    issue(1'b1, 7'h10, 32'h0000AB00, 4'b0010);
    check_rsp("partial_ack");
    issue(1'b0, 7'h10, 32'h0, 4'h0);
    check_rsp("partial_rd");
    chk("partial_model", rd_word(16), 32'hDEADABEF);
    issue(1'b0, 7'h12, 32'h0, 4'h0);
    check_rsp("misaligned");
    issue(1'b0, 7'h40, 32'h0, 4'h0);
    check_rsp("out_of_range");
    issue(1'b1, 7'h14, 32'h12345678, 4'h0);
    check_rsp("zero_strb_ack");
    issue(1'b0, 7'h14, 32'h0, 4'h0);
    check_rsp("zero_strb_rd");

    bus.rsp_ready = 1'b0;
    ea = rd_word(16);
    eb = rd_word(20);
    ec = rd_word(24);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 7'h10;
    #1;
    chk("bp_ready_a", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req_addr = 7'h14;
    #1;
    chk("bp_ready_b", bus.req_ready, 1'b1);
    chk("bp_valid_a", bus.rsp_valid, 1'b1);
    @(posedge clk);
    #1;
    bus.req_addr = 7'h18;
    #1;
    chk("bp_full", bus.req_ready, 1'b0);
    chk("bp_head_a", bus.rsp_rdata, ea);
    @(posedge clk);
    #2;
    chk("bp_hold_full", bus.req_ready, 1'b0);
    chk("bp_hold_head", bus.rsp_rdata, ea);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_pop_cycle_ready", bus.req_ready, 1'b0);
    chk("bp_pop_head_a", bus.rsp_rdata, ea);
    @(posedge clk);
    #2;
    chk("bp_after_pop_ready", bus.req_ready, 1'b1);
    chk("bp_head_b", bus.rsp_rdata, eb);
    chk("bp_en_c", sram_en, 1'b1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    #1;
    chk("bp_head_c", bus.rsp_rdata, ec);
    chk("bp_valid_c", bus.rsp_valid, 1'b1);
    @(posedge clk);
    #2;
    chk("bp_drained", bus.rsp_valid, 1'b0);
    @(posedge clk);
    #1;

    for (int n = 0; n < 48; n++) begin
      mode = int'($urandom_range(0, 7));
      if (mode == 0) a = 7'(($urandom_range(0, 15) * 4) + $urandom_range(1, 3));
      else if (mode == 1) a = 7'($urandom_range(64, 127));
      else a = 7'($urandom_range(0, 15) * 4);
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      check_rsp("random");
    end

    bus.rsp_ready = 1'b0;
    issue(1'b1, 7'h08, 32'hA5A5_5A5A, 4'hF);
    issue(1'b0, 7'h08, 32'h0, 4'h0);
    rst = 1'b1;
    #1;
    @(posedge clk);
    #2;
    chk("run_rst_flush_valid", bus.rsp_valid, 1'b0);
    chk("run_rst_flush_rdata", bus.rsp_rdata, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    release_run();
    issue(1'b0, 7'h08, 32'h0, 4'h0);
    check_rsp("post_rst_rd");
    issue(1'b0, 7'h10, 32'h0, 4'h0);
    check_rsp("post_rst_rd2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_sram_ctrl.md
# pe_sram_ctrl

Request/response front end that sits directly upstream of `pe_sram` in the PE tile and is the only agent driving its port. It accepts byte-addressed read/write requests on a valid/ready channel, range- and alignment-checks them, and drives the SRAM's single port. It returns one response per request through a 2-entry response FIFO. Optionally, it zero-fills the whole array after reset before accepting traffic.

## Interface
Parameters:
- `SIZE`, 4096, SRAM size in bytes; multiple of 4.
- `DATA_W`, 32, word width; only 32 is supported.
- `ADR_W`, 12, SRAM word-address width; `2**ADR_W >= SIZE/4`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADR_W+2  byte address.
- `req_wdata`  in  DATA_W  write data.
- `req_wstrb`  in  DATA_W/8  byte enables.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and errors.
- `rsp_err`  out  1  request rejected: misaligned or out of range.
- `init_done`  out  1  high once the controller is in RUN.
- `sram_en`, `sram_we`  out  1 each  SRAM strobes.
- `sram_addr`  out  ADR_W  SRAM word address.
- `sram_wdata`  out  DATA_W  SRAM write data.
- `sram_wstrb`  out  DATA_W/8  SRAM byte enables.
- `sram_rdata`  in  DATA_W  combinational SRAM read data; valid in the same cycle as `en && !we`.

## Operation
- **FSM states:** INIT, RUN.
  - Reset enters INIT when the macro is defined, otherwise RUN.
  - INIT→RUN after the last word is written. RUN is terminal until reset.
- **INIT:**
  - Word counter runs 0..SIZE/4-1, one word per cycle.
  - SRAM drive: `sram_en=1`, `sram_we=1`, `sram_wstrb` all ones, `sram_wdata=0`.
  - `req_ready=0` throughout.
- **RUN decode:**
  - `word = req_addr[ADR_W+1:2]`.
  - `err = (req_addr[1:0]!=0) || (word >= SIZE/4)`.
- **Accept:** `req_ready = RUN && fifo_count<2`.
- **Accepted request with no error:**
  - SRAM drive, combinational in the accept cycle: `sram_en=1`, `sram_we=req_we`, `sram_addr=word`, `sram_wdata`/`sram_wstrb` passed through.
  - Read: push `{sram_rdata, err=0}`.
  - Write: push `{0, err=0}`.
  - A write with `wstrb=0` still gets a normal ack.
- **Accepted request with error:** no SRAM access (`sram_en=0`); push `{0, err=1}`.
- **Idle cycles:** all `sram_*` outputs are 0.
- **Response FIFO:**
  - 2 entries, in order.
  - Simultaneous push and pop allowed at any count; count is unchanged.
  - Head drives `rsp_*`.

## Timing
- **Reset values:** `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `init_done=0`, all `sram_*=0`, FIFO empty, init counter 0.
- **Latency:** accept at edge N gives `rsp_valid` high from the cycle after N.
- **Throughput:** one request per cycle while `rsp_ready=1`.
- **Backpressure:** `rsp_valid` and `rsp_*` hold stable until popped.
  - With `rsp_ready=0`, two requests are accepted, then `req_ready` drops.
  - `req_ready` rises the cycle after a pop.
- **Init duration:** exactly SIZE/4 cycles after reset release. `init_done` and `req_ready` rise in the following cycle.
- **Reset mid-operation:**
  - Reset during INIT restarts the walk from word 0.
  - Reset in RUN flushes the FIFO and drops queued responses.

## Configuration
- **`PE_SRAM_CTRL_INIT_EN` defined:** INIT zero-fill as described above.
- **Macro undefined:**
  - No INIT state and no init counter.
  - RUN is entered on the first cycle after reset; `init_done=1` and `req_ready=1` then.
  - Array contents rely on the SRAM's own power-up values.

## Structure
- Shared package `pe_pkg`:
  - state enum `{ST_INIT, ST_RUN}`.
  - response entry struct `{rdata, err}`.
  - `PE_SRAM_RSP_DEPTH=2` constant.
- Natural sub-module: `pe_rsp_fifo`, a generic 2-entry synchronous FIFO with count, push, and pop. The FSM, decode, and SRAM drive stay in the top.

## Test plan
- **Init:** SIZE=64, macro on; release reset.
  - 16 zero-writes to words 0..15 with `wstrb=4'hF`.
  - `req_ready` rises in cycle 17.
- **Write then read:** write 0xDEADBEEF to 0x010 with wstrb 4'hF, then read 0x010.
  - Ack has `rsp_err=0`, `rdata=0`.
  - Read returns 0xDEADBEEF one cycle after accept.
- **Partial write:** wstrb 4'b0010 with 0x0000AB00 onto 0xDEADBEEF at the same address; read returns 0xDEADABEF.
- **Errors:**
  - Read 0x012: `rsp_err=1`, `rdata=0`, no `sram_en`.
  - Read 0x1000 with SIZE=4096: `rsp_err=1`, no `sram_en`.
- **Backpressure:** `rsp_ready=0` with three back-to-back reads.
  - Only two are accepted; `req_ready=0`.
  - Raising `rsp_ready` drains in order and accepts the third.
- **Reset mid-init:** assert `rst` at init word 5; the walk restarts at word 0 and the full SIZE/4 walk repeats.
